conv_stream_feeder: RTL and testbench

//  Transmit side of the convolution input stream. On a start pulse, reads one
//  14x14 IFM frame and one 3x3 kernel from two synchronous read memories.

---
 rtl/conv_stream_feeder_pkg.sv | 18 +
 rtl/conv_feed_addr_gen.sv | 35 +++
 rtl/conv_stream_feeder.sv | 138 +++++++++++++
 tb/tb_conv_stream_feeder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_feeder_pkg.sv
// Shared frame constants and feeder state encoding.
// The convolution core imports the same frame geometry.
package conv_stream_feeder_pkg;

   localparam int IMG_W = 14;
   localparam int IMG_H = 14;
   localparam int K     = 3;
   localparam int N     = IMG_W * IMG_H;
   localparam int KK    = K * K;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_GAP    = 2'd3
   } feed_state_t;

endpackage

// File: rtl/conv_feed_addr_gen.sv
// Beat counter for the feeder: raster beat index, last-beat
// flag and "next beat still inside the weight window" flag.
module conv_feed_addr_gen #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_adv,
   output logic [ADDR_W-1:0] o_beat,
   output logic              o_last,
   output logic              o_win_nxt
);
   import conv_stream_feeder_pkg::*;

   logic [ADDR_W-1:0] r_beat;
   logic [ADDR_W-1:0] w_nxt;

   assign w_nxt     = r_beat + ADDR_W'(1);
   assign o_last    = (r_beat == ADDR_W'(N - 1));
   assign o_win_nxt = (w_nxt < ADDR_W'(KK));
   assign o_beat    = r_beat;

   // Count beats; saturate at the last beat so the address never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat <= '0;
      end else if (i_clr) begin
         r_beat <= '0;
      end else if (i_adv && !o_last) begin
         r_beat <= w_nxt;
      end
   end

endmodule

// File: rtl/conv_stream_feeder.sv
// Reads one IFM frame and one kernel from 1-clk SRAMs and
// streams them, one word per clock, into the convolution core.
module conv_stream_feeder #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ifm_rd_en,
   output logic [ADDR_W-1:0] ifm_addr,
   input  logic [DATA_W-1:0] ifm_rdata,
   output logic              w_rd_en,
   output logic [3:0]        w_addr,
   input  logic [DATA_W-1:0] w_rdata,
   output logic              in_valid,
   output logic [DATA_W-1:0] In_IFM,
   output logic [DATA_W-1:0] In_Weight
);
   import conv_stream_feeder_pkg::*;

   feed_state_t       r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_ifm_rd_en;
   logic              r_w_rd_en;
   logic [3:0]        r_w_addr;
   logic [7:0]        r_gap;
   logic              r_v1;
   logic              r_wsel1;
   logic              r_in_valid;
   logic [DATA_W-1:0] r_ifm;
   logic [DATA_W-1:0] r_wt;

   logic [ADDR_W-1:0] w_beat;
   logic              w_last;
   logic              w_win_nxt;
   logic              w_clr;
   logic              w_adv;

   // A start seen while done is still showing waits one more clock.
   assign w_clr = (r_state == S_IDLE) && start && !r_done;
   assign w_adv = (r_state == S_STREAM) && !w_last;

   conv_feed_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_adv     (w_adv),
      .o_beat    (w_beat),
      .o_last    (w_last),
      .o_win_nxt (w_win_nxt)
   );

   // Frame sequencing: read strobes, gap timing, busy/done.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ifm_rd_en <= 1'b0;
         r_w_rd_en   <= 1'b0;
         r_w_addr    <= '0;
         r_gap       <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_busy <= 1'b0;
               if (w_clr) begin
                  r_state     <= S_STREAM;
                  r_busy      <= 1'b1;
                  r_ifm_rd_en <= 1'b1;
                  r_w_rd_en   <= 1'b1;
                  r_w_addr    <= '0;
               end
            end
            S_STREAM: begin
               if (w_last) begin
                  r_ifm_rd_en <= 1'b0;
                  r_w_rd_en   <= 1'b0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_w_rd_en <= w_win_nxt;
                  if (w_win_nxt) begin
                     r_w_addr <= r_w_addr + 4'd1;
                  end
               end
            end
            S_DRAIN: begin
               r_gap   <= '0;
               r_state <= S_GAP;
            end
            S_GAP: begin
               if (r_gap == 8'(GAP_CYC - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap + 8'd1;
               end
            end
         endcase
      end
   end

   // One-stage valid pipe aligning beats with the 1-clk read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1       <= 1'b0;
         r_wsel1    <= 1'b0;
         r_in_valid <= 1'b0;
         r_ifm      <= '0;
         r_wt       <= '0;
      end else begin
         r_v1       <= r_ifm_rd_en;
         r_wsel1    <= r_w_rd_en;
         r_in_valid <= r_v1;
         r_ifm      <= r_v1 ? ifm_rdata : '0;
         r_wt       <= (r_v1 && r_wsel1) ? w_rdata : '0;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign ifm_rd_en = r_ifm_rd_en;
   assign ifm_addr  = w_beat;
   assign w_rd_en   = r_w_rd_en;
   assign w_addr    = r_w_addr;
   assign in_valid  = r_in_valid;
   assign In_IFM    = r_ifm;
   assign In_Weight = r_wt;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed + randomized bench for conv_stream_feeder with
// 1-clk memory models and a stream-level reference model.
module tb_conv_stream_feeder;
   import conv_stream_feeder_pkg::*;

   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int GAP = 2;
   // Held start: GAP low clks (done on the last), one clk where the
   // start is deferred past done, then two clks of read latency.
   localparam int EXP_GAP = GAP + 1 + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, ifm_rd_en, w_rd_en, in_valid;
   logic [AW-1:0] ifm_addr;
   logic [3:0]    w_addr;
   logic [DW-1:0] ifm_rdata = '0;
   logic [DW-1:0] w_rdata = '0;
   logic [DW-1:0] In_IFM, In_Weight;

   conv_stream_feeder #(
      .DATA_W (DW), .ADDR_W (AW), .GAP_CYC (GAP)
   ) dut (
      .clk (clk), .rst (rst), .start (start),
      .busy (busy), .done (done),
      .ifm_rd_en (ifm_rd_en), .ifm_addr (ifm_addr),
      .ifm_rdata (ifm_rdata),
      .w_rd_en (w_rd_en), .w_addr (w_addr), .w_rdata (w_rdata),
      .in_valid (in_valid), .In_IFM (In_IFM),
      .In_Weight (In_Weight)
   );

   always #5 clk = ~clk;

   int ifm_mem [N];
   int w_mem [KK];

   // memory models, one clock of read latency
   always @(posedge clk) begin
      if (ifm_rd_en) ifm_rdata <= DW'(ifm_mem[ifm_addr]);
      if (w_rd_en)   w_rdata   <= DW'(w_mem[w_addr]);
   end

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int q_ifm[$];
   int q_wt[$];
   int run_start[$];
   int run_end[$];
   int gaps[$];
   int done_cyc[$];
   int busy_low;
   int rd_cnt;
   logic prev_v;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_rec();
      q_ifm.delete(); q_wt.delete();
      run_start.delete(); run_end.delete(); gaps.delete();
      done_cyc.delete();
      busy_low = 0; rd_cnt = 0; prev_v = 1'b0;
   endtask

   // advance one clock and record what the stream did
   task automatic step();
      @(posedge clk); #1; cyc++;
      if (in_valid) begin
         if (!prev_v) begin
            if (run_end.size() > 0)
               gaps.push_back(cyc - run_end[$] - 1);
            run_start.push_back(cyc);
         end
         q_ifm.push_back(int'(In_IFM));
         q_wt.push_back(int'(In_Weight));
      end else if (prev_v) begin
         run_end.push_back(cyc - 1);
      end
      prev_v = in_valid;
      if (done) done_cyc.push_back(cyc);
      if (!busy) busy_low++;
      if (ifm_rd_en || w_rd_en) rd_cnt++;
   endtask

   task automatic run(input string tag, input int budget,
                      input int ndone);
      int n = 0;
      while (done_cyc.size() < ndone && n < budget) begin
         step(); n++;
      end
      chk(tag, 32'(done_cyc.size() >= ndone), 1);
   endtask

   // reference: every frame is ifm_mem in raster order, weights
   // on the first KK beats, zero weight afterwards
   task automatic chk_stream(input string tag, input int nfr);
      int bad_d = 0;
      int bad_w = 0;
      chk({tag, "_len"}, q_ifm.size(), nfr * N);
      for (int i = 0; i < q_ifm.size() && i < nfr * N; i++) begin
         int b = i % N;
         int ew = (b < KK) ? w_mem[b] : 0;
         if (q_ifm[i] != ifm_mem[b]) bad_d++;
         if (q_wt[i] != ew) bad_w++;
      end
      chk({tag, "_ifm"}, bad_d, 0);
      chk({tag, "_wt"}, bad_w, 0);
   endtask

   task automatic fill_formula();
      for (int a = 0; a < N; a++) ifm_mem[a] = a + 1;
      for (int k = 0; k < KK; k++) w_mem[k] = k + 10;
   endtask

   task automatic fill_rand();
      for (int a = 0; a < N; a++)
         ifm_mem[a] = int'($urandom_range(65535, 0));
      for (int k = 0; k < KK; k++)
         w_mem[k] = int'($urandom_range(65535, 0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int n;
      int bl;
      int ofm_bad;
      int s;

      // 1: reset
      clr_rec();
      repeat (3) step();
      chk("rst_ctl", {busy, done, ifm_rd_en, w_rd_en, in_valid}, 0);
      chk("rst_addr", {ifm_addr, w_addr}, 0);
      chk("rst_data", {In_IFM, In_Weight}, 0);
      rst = 1'b0;
      clr_rec();
      repeat (5) step();
      chk("idle_rd", rd_cnt, 0);
      chk("idle_busy", busy_low, 5);

      // 2: single frame, formula data
      fill_formula();
      clr_rec();
      start = 1'b1; step(); c0 = cyc; start = 1'b0;
      chk("t2_busy_acc", busy, 1);
      run("t2_done_tmo", 400, 1);
      repeat (3) step();
      chk_stream("t2", 1);
      chk("t2_runs", run_start.size(), 1);
      chk("t2_lat", (run_start.size() > 0) ? run_start[0] - c0 : -1, 2);
      chk("t2_first", (q_ifm.size() > 0) ? q_ifm[0] : -1, 1);
      chk("t2_last", (q_ifm.size() == N) ? q_ifm[N-1] : -1, N);
      chk("t2_w8", (q_wt.size() > 9) ? q_wt[8] : -1, 18);
      chk("t2_w9", (q_wt.size() > 9) ? q_wt[9] : -1, 0);
      chk("t2_ndone", done_cyc.size(), 1);
      chk("t2_done_ofs",
          (done_cyc.size() > 0 && run_end.size() > 0) ?
          done_cyc[0] - run_end[0] : -1, GAP);
      chk("t2_busy_low", busy_low, 3);
      chk("t2_addr_hold", ifm_addr, N - 1);
      chk("t2_idle_data", {in_valid, In_IFM, In_Weight}, 0);

      // 3: start re-pulsed mid-frame and near the end
      fill_rand();
      clr_rec();
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (done_cyc.size() < 1 && n < 400) begin
         start = (q_ifm.size() == 50 || q_ifm.size() == 195);
         step(); n++;
      end
      start = 1'b0;
      chk("t3_done_tmo", 32'(done_cyc.size() >= 1), 1);
      repeat (10) step();
      chk_stream("t3", 1);
      chk("t3_runs", run_start.size(), 1);
      chk("t3_ndone", done_cyc.size(), 1);

      // 4: start held for three frames
      fill_rand();
      clr_rec();
      start = 1'b1;
      n = 0;
      while (done_cyc.size() < 3 && n < 1200) begin
         step(); n++;
      end
      start = 1'b0;
      bl = busy_low;
      chk("t4_done_tmo", 32'(done_cyc.size() >= 3), 1);
      repeat (6) step();
      chk_stream("t4", 3);
      chk("t4_runs", run_start.size(), 3);
      chk("t4_ngaps", gaps.size(), 2);
      for (int g = 0; g < gaps.size(); g++)
         chk("t4_gap", gaps[g], EXP_GAP);
      chk("t4_busy_low", bl, 2);
      chk("t4_ndone", done_cyc.size(), 3);

      // 5: reset at beat 100, then a fresh frame
      fill_rand();
      clr_rec();
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (q_ifm.size() < 100 && n < 300) begin
         step(); n++;
      end
      chk("t5_reach", q_ifm.size(), 100);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t5_abort", {in_valid, busy, ifm_rd_en}, 0);
      repeat (20) step();
      chk("t5_ndone", done_cyc.size(), 0);
      chk("t5_beats", q_ifm.size(), 100);
      fill_formula();
      clr_rec();
      start = 1'b1; step(); start = 1'b0;
      run("t5_done_tmo", 400, 1);
      repeat (3) step();
      chk("t5_first", (q_ifm.size() > 0) ? q_ifm[0] : -1, 1);
      chk("t5_w0", (q_wt.size() > 0) ? q_wt[0] : -1, 10);
      chk_stream("t5", 1);

      // 6: loopback into a 3x3 valid convolution, all-ones data
      for (int a = 0; a < N; a++) ifm_mem[a] = 1;
      for (int k = 0; k < KK; k++) w_mem[k] = 1;
      clr_rec();
      start = 1'b1; step(); start = 1'b0;
      run("t6_done_tmo", 400, 1);
      repeat (3) step();
      chk("t6_len", q_ifm.size(), N);
      ofm_bad = 0;
      if (q_ifm.size() == N) begin
         for (int r = 0; r <= IMG_H - K; r++)
            for (int c = 0; c <= IMG_W - K; c++) begin
               s = 0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     s += q_ifm[(r + i) * IMG_W + c + j] * q_wt[i * K + j];
               if (s != 9) ofm_bad++;
            end
      end else begin
         ofm_bad = -1;
      end
      chk("t6_ofm", ofm_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
